// File: rtl/sram_wr_demux4_pkg.sv
// Shared constants and helpers for the 4-bank SRAM write demultiplexer.
package sram_wr_demux4_pkg;

  localparam int unsigned SRAM_NBANK      = 4;
  localparam int unsigned SRAM_BSEL_W     = 2;
  localparam int unsigned SRAM_WIDTH_DEF  = 32;
  localparam int unsigned SRAM_ADDR_W_DEF = 16;
  localparam int unsigned SRAM_SEL_LSB_DEF = 2;

  function automatic logic [SRAM_NBANK-1:0] bank_onehot(input logic [SRAM_BSEL_W-1:0] sel);
    logic [SRAM_NBANK-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/sram_wr_slot.sv
// One-entry valid/ready holding register for a single bank write port.
module sram_wr_slot #(
  parameter int unsigned PW = 48
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_fill,
  input  logic [PW-1:0] i_payload,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [PW-1:0] o_payload
);

  logic          r_valid;
  logic [PW-1:0] r_payload;

  // A fill in the same cycle as a drain replaces the word and keeps valid high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (i_fill) begin
      r_valid   <= 1'b1;
      r_payload <= i_payload;
    end else if (r_valid && i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;

endmodule

// File: rtl/sram_wr_demux4.sv
// Routes one write request stream to four SRAM bank write ports, one holding slot per bank.
// Optional byte strobes are enabled with SRAM_WR_STRB_EN.
module sram_wr_demux4
  import sram_wr_demux4_pkg::*;
#(
  parameter int unsigned WIDTH   = SRAM_WIDTH_DEF,
  parameter int unsigned ADDR_W  = SRAM_ADDR_W_DEF,
  parameter int unsigned SEL_LSB = SRAM_SEL_LSB_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [ADDR_W-1:0]            i_in_addr,
  input  logic [WIDTH-1:0]             i_in_data,
`ifdef SRAM_WR_STRB_EN
  input  logic [WIDTH/8-1:0]           i_in_strb,
  output logic [SRAM_NBANK*WIDTH/8-1:0] o_bank_strb,
`endif
  output logic [SRAM_NBANK-1:0]        o_bank_valid,
  input  logic [SRAM_NBANK-1:0]        i_bank_ready,
  output logic [SRAM_NBANK*ADDR_W-1:0] o_bank_addr,
  output logic [SRAM_NBANK*WIDTH-1:0]  o_bank_data,
  output logic                         o_busy
);

`ifdef SRAM_WR_STRB_EN
  localparam int unsigned STRB_W = WIDTH / 8;
  localparam int unsigned PW     = STRB_W + ADDR_W + WIDTH;
`else
  localparam int unsigned PW     = ADDR_W + WIDTH;
`endif

  logic [SRAM_BSEL_W-1:0] w_sel;
  logic                   w_slot_free;
  logic                   w_skip;
  logic                   w_accept;
  logic [SRAM_NBANK-1:0]  w_fill;
  logic [SRAM_NBANK-1:0]  w_valid;
  logic [PW-1:0]          w_in_payload;
  logic [PW-1:0]          w_out_payload [SRAM_NBANK];

  assign w_sel       = i_in_addr[SEL_LSB +: SRAM_BSEL_W];
  assign w_slot_free = ~w_valid[w_sel] | i_bank_ready[w_sel];

`ifdef SRAM_WR_STRB_EN
  // An all-zero strobe writes nothing, so it completes without touching any slot.
  assign w_skip       = (i_in_strb == '0);
  assign w_in_payload = {i_in_strb, i_in_addr, i_in_data};
`else
  assign w_skip       = 1'b0;
  assign w_in_payload = {i_in_addr, i_in_data};
`endif

  assign o_in_ready = ~i_rst & (w_skip | w_slot_free);
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_fill     = (w_accept && !w_skip) ? bank_onehot(w_sel) : '0;

  for (genvar g = 0; g < SRAM_NBANK; g++) begin : g_slot
    sram_wr_slot #(
      .PW (PW)
    ) u_slot (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_fill    (w_fill[g]),
      .i_payload (w_in_payload),
      .i_ready   (i_bank_ready[g]),
      .o_valid   (w_valid[g]),
      .o_payload (w_out_payload[g])
    );

    assign o_bank_data[g*WIDTH +: WIDTH]   = w_out_payload[g][WIDTH-1:0];
    assign o_bank_addr[g*ADDR_W +: ADDR_W] = w_out_payload[g][WIDTH +: ADDR_W];
`ifdef SRAM_WR_STRB_EN
    assign o_bank_strb[g*STRB_W +: STRB_W] = w_out_payload[g][ADDR_W+WIDTH +: STRB_W];
`endif
  end

  assign o_bank_valid = w_valid;
  assign o_busy       = |w_valid;

endmodule
